// File: rtl/nibble_serial_adder_if.sv
// Operand and result handshake bundle for the nibble-serial adder.
// The slave side is the adder; the master side is the producer/consumer.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport slave (
        input  in_valid,
        output in_ready,
        input  a,
        input  b,
        input  cin,
        input  sub,
        output out_valid,
        input  out_ready,
        output sum,
        output cout,
        output overflow
    );

    modport master (
        output in_valid,
        input  in_ready,
        output a,
        output b,
        output cin,
        output sub,
        input  out_valid,
        output out_ready,
        input  sum,
        input  cout,
        input  overflow
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder/subtractor driving one 4-bit carry-lookahead slice,
// one nibble per cycle, least significant first.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0])
                | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign s     = p ^ c[3:0];
    assign c_out = c[4];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    nibble_serial_adder_if.slave bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IW      = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic [3:0] nib_s;
    logic       nib_c;
    logic       last;
    logic       accept;

    assign nib_a  = a_q[{idx, 2'b00} +: 4];
    assign nib_b  = b_q[{idx, 2'b00} +: 4];
    assign last   = (idx == LAST);
    assign accept = (state == IDLE) && bus.in_valid;

    cla4_slice u_slice (
        .a     (nib_a),
        .b     (nib_b),
        .c_in  (carry_q),
        .s     (nib_s),
        .c_out (nib_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Subtraction is a + ~b + 1, so the inversion and forced carry
    // are folded into the operand latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub | bus.cin;
            idx     <= '0;
        end else if (state == RUN) begin
            carry_q <= nib_c;
            idx     <= last ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state == RUN) begin
            sum_q[{idx, 2'b00} +: 4] <= nib_s;
            if (last) begin
                cout_q <= nib_c;
                ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1])
                       && (nib_s[3] != a_q[WIDTH-1]);
            end
        end
    end

    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule
